imm_encoder: RTL
================

# imm_encoder

Multi-cycle encoder producing the 12-bit shifter operand that the execute stage's operand-2 generator decodes. It takes a 32-bit constant plus a load/store flag and searches for an encoding the decoder maps back to the same value. In the immediate path this is an 8-bit immediate with a 4-bit rotate field; in the load/store path it is a 12-bit signed offset. It sits beside the instruction-memory loader / test harness and is also used to cross-check operand-2 decoding in simulation.

## Interface
- ROT_STEPS, 16, number of rotate-field values searched (value field is 4 bits; fixed).
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  request present.
- in_ready  out  1  high only in IDLE.
- in_value  in  32  constant to encode.
- in_ld_str  in  1  1 = encode as 12-bit signed memory offset; 0 = encode as rotated immediate.
- out_valid  out  1  result present; held until accepted.
- out_ready  in  1  consumer accepts result.
- out_ok  out  1  1 = encodable; 0 = no encoding exists.
- out_imm  out  1  1 = rotated-immediate result (I bit); 0 = offset result.
- out_shift_operand  out  12  encoding; 12'h000 whenever out_ok = 0.

## Operation
- States: IDLE, SEARCH, DONE. Reset forces IDLE and sets every output to 0 except in_ready = 1 (IDLE). work, rot_cnt and the result registers are also cleared.
- Accept: the transfer occurs when in_valid && in_ready. Inputs are sampled only on that edge.
- Offset path (in_ld_str = 1):
  - Go directly to DONE.
  - out_ok = 1 iff in_value[31:11] are all equal (value fits signed 12 bits).
  - out_shift_operand = in_value[11:0] when ok.
  - out_imm = 0.
- Immediate path (in_ld_str = 0):
  - Load work = in_value and rot_cnt = 0, then go to SEARCH.
  - Encoding rule: value = ROR(zero-extended imm8, 2·rot). Equivalently, imm8 = ROL(value, 2·rot) with the upper 24 bits zero.
- SEARCH, evaluated once per cycle:
  - If work[31:8] == 0: result = {rot_cnt, work[7:0]}, ok = 1, imm = 1, go to DONE.
  - Else if rot_cnt == 15: ok = 0, result = 0, imm = 1, go to DONE.
  - Else: work = ROL(work, 2), rot_cnt = rot_cnt + 1.
- The smallest rot satisfying the rule wins. Value 0 encodes as 12'h000.
- DONE:
  - out_valid = 1, with outputs registered and stable.
  - When out_ready is high: go to IDLE; out_valid drops the next cycle.
- rot_cnt is 4 bits and never wraps; the terminal test at 15 precedes the increment.
- Reset mid-operation: any state goes to IDLE in one cycle. A pending result is discarded with no out_valid pulse.

## Timing
- Request accepted at edge 0.
- Offset path: out_valid high after edge 1.
- Immediate path, hit at rot = r: out_valid high after edge r+2. Best case is 2 cycles (r = 0); worst case is 17 cycles (rot 15 or a failure).
- Back-to-back throughput:
  - in_ready returns the cycle after the out_valid/out_ready transfer.
  - There is no overlap of requests.
  - Minimum period is 3 cycles (immediate path) or 2 cycles (offset path).
- out_ready is ignored outside DONE.
- in_valid is ignored outside IDLE; the request remains pending on the requester's side.

## Structure
- Shared package:
  - State enum (IDLE, SEARCH, DONE).
  - ROT_STEPS = 16.
  - Field positions: ROT_MSB = 11, ROT_LSB = 8, IMM8_MSB = 7.
  - A function fits_s12(value).
- These constants are shared with the operand-2 generator and the bench reference model.
- Single module. No sub-module is warranted; the rotate-by-2 and fit checks are inline expressions.

## Test plan
- Value 0x000000FF, ld_str = 0 → ok = 1, operand 12'h0FF, out_valid at cycle 2.
- Value 0xFF000000, then 0xF000000F → 12'h4FF at cycle 6, then 12'h2FF at cycle 4.
- Value 0x00000104 → 12'hF41 at cycle 17. Value 0x00000101 → ok = 0, operand 12'h000 at cycle 17.
- ld_str = 1, value 0xFFFFF800 → ok = 1, imm = 0, operand 12'h800 at cycle 1. Value 0x00000800 → ok = 0.
- Hold out_ready low 3 cycles in DONE → outputs stable, in_ready = 0, and a new in_valid is not accepted. Release → IDLE next cycle.
- Assert rst in SEARCH at rot_cnt = 5 → IDLE next cycle, out_valid never rises. The next request 0x3FC encodes 12'hFFF correctly.

Source files
------------

// File: rtl/imm_encoder_pkg.sv
// Shared definitions for the operand-2 immediate/offset encoder.
// The field positions are shared with the operand-2 generator and the bench reference model.
package imm_encoder_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SEARCH,
    DONE
  } state_t;

  localparam int ROT_STEPS = 16;
  localparam int ROT_MSB   = 11;
  localparam int ROT_LSB   = 8;
  localparam int IMM8_MSB  = 7;

  localparam logic [3:0] ROT_LAST = 4'(ROT_STEPS - 1);

  // True when value sign-extends cleanly from 12 bits.
  function automatic logic fits_s12(input logic [31:0] value);
    return (value[31:11] == '0) || (value[31:11] == '1);
  endfunction

endpackage

// File: rtl/imm_encoder_if.sv
// Request/result handshake bundle between a requester and imm_encoder.
interface imm_encoder_if;

  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_value;
  logic        in_ld_str;
  logic        out_valid;
  logic        out_ready;
  logic        out_ok;
  logic        out_imm;
  logic [11:0] out_shift_operand;

  modport master (
    output in_valid, in_value, in_ld_str, out_ready,
    input  in_ready, out_valid, out_ok, out_imm, out_shift_operand
  );

  modport slave (
    input  in_valid, in_value, in_ld_str, out_ready,
    output in_ready, out_valid, out_ok, out_imm, out_shift_operand
  );

endinterface

// File: rtl/imm_encoder.sv
// Multi-cycle encoder: finds an 8-bit/rotate-4 immediate or a signed 12-bit offset for a 32-bit constant.
// The rotate search tries one rotate value per cycle so the smallest rotate is found first.
module imm_encoder
  import imm_encoder_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  imm_encoder_if.slave bus
);

  state_t      r_state;
  logic [31:0] r_work;
  logic [3:0]  r_rotCnt;
  logic        r_ok;
  logic        r_imm;
  logic [11:0] r_operand;

  state_t      w_nextState;
  logic [31:0] w_work;
  logic [3:0]  w_rotCnt;
  logic        w_ok;
  logic        w_imm;
  logic [11:0] w_operand;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_work    <= '0;
      r_rotCnt  <= '0;
      r_ok      <= 1'b0;
      r_imm     <= 1'b0;
      r_operand <= '0;
    end else begin
      r_state   <= w_nextState;
      r_work    <= w_work;
      r_rotCnt  <= w_rotCnt;
      r_ok      <= w_ok;
      r_imm     <= w_imm;
      r_operand <= w_operand;
    end
  end

  // Result registers only change on accept (offset) or at the end of the search.
  always_comb begin
    w_nextState = r_state;
    w_work      = r_work;
    w_rotCnt    = r_rotCnt;
    w_ok        = r_ok;
    w_imm       = r_imm;
    w_operand   = r_operand;
    case (r_state)
      IDLE: begin
        if (bus.in_valid) begin
          if (bus.in_ld_str) begin
            w_ok        = fits_s12(bus.in_value);
            w_imm       = 1'b0;
            w_operand   = fits_s12(bus.in_value) ? bus.in_value[11:0] : 12'h000;
            w_nextState = DONE;
          end else begin
            w_work      = bus.in_value;
            w_rotCnt    = 4'd0;
            w_nextState = SEARCH;
          end
        end
      end
      SEARCH: begin
        if (r_work[31:IMM8_MSB+1] == '0) begin
          w_ok                        = 1'b1;
          w_imm                       = 1'b1;
          w_operand[ROT_MSB:ROT_LSB]  = r_rotCnt;
          w_operand[IMM8_MSB:0]       = r_work[IMM8_MSB:0];
          w_nextState                 = DONE;
        end else if (r_rotCnt == ROT_LAST) begin
          w_ok        = 1'b0;
          w_imm       = 1'b1;
          w_operand   = 12'h000;
          w_nextState = DONE;
        end else begin
          w_work   = {r_work[29:0], r_work[31:30]};
          w_rotCnt = r_rotCnt + 4'd1;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          w_nextState = IDLE;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  assign bus.in_ready          = (r_state == IDLE);
  assign bus.out_valid         = (r_state == DONE);
  assign bus.out_ok            = r_ok;
  assign bus.out_imm           = r_imm;
  assign bus.out_shift_operand = r_operand;

endmodule
